// File: rtl/register_file_param.sv
// register_file_param
//   Parameterised register file with two combinational read ports, one
//   synchronous write port with same-cycle write-to-read bypass, and a
//   self-clearing sweep engine that zeroes every register, one per cycle.
//
//   Parameters
//     WIDTH    data word width
//     AW       address width, DEPTH = 2**AW registers
//     ZERO_REG 1: register 0 reads as zero and ignores writes
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; forces a fresh sweep
//     rs/rt  read addresses, ports A/B
//     rw     write address
//     dw     write data
//     rwe    write enable
//     clr    soft-clear request, starts a sweep from IDLE
//     crs    read data port A (0 while busy)
//     crt    read data port B (0 while busy)
//     busy   high while the sweep is running (registered, state==SWEEP)
//
//   Handshake: there is no valid/ready pair. A write is accepted on a rising
//   edge only when rwe=1, clr=0 and busy=0; anything presented while busy=1,
//   or in the same cycle as clr, is dropped without notice.
module register_file_param #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic [AW-1:0]    rw,
  input  logic [WIDTH-1:0] dw,
  input  logic             rwe,
  input  logic             clr,
  output logic [WIDTH-1:0] crs,
  output logic [WIDTH-1:0] crt,
  output logic             busy
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              wr_en;

  // Write acceptance. Writes to register 0 are suppressed entirely when it
  // is hardwired, which also keeps it out of the bypass path.
  always_comb begin
    wr_en = (state_q == IDLE) && rwe && !clr;
    if ((ZERO_REG != 0) && (rw == '0)) begin
      wr_en = 1'b0;
    end
  end

  // Next-state logic. The pointer wraps naturally from all-ones to zero on
  // the final sweep edge, so it is already 0 for the next sweep.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = SWEEP;
        ptr_d   = '0;
      end
    endcase
  end

  // Reset parks the FSM in SWEEP at pointer 0: the array itself has no
  // reset and is zeroed by the sweep that runs once reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == SWEEP) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_en) begin
      mem_q[rw] <= dw;
    end
  end

  assign busy = (state_q == SWEEP);

  // Read ports: forced to zero during a sweep, hardwired zero for address 0
  // when enabled, otherwise bypass a same-cycle write before the array.
  always_comb begin
    crs = '0;
    if (!busy) begin
      if ((ZERO_REG != 0) && (rs == '0)) begin
        crs = '0;
      end else if (wr_en && (rs == rw)) begin
        crs = dw;
      end else begin
        crs = mem_q[rs];
      end
    end
  end

  always_comb begin
    crt = '0;
    if (!busy) begin
      if ((ZERO_REG != 0) && (rt == '0)) begin
        crt = '0;
      end else if (wr_en && (rt == rw)) begin
        crt = dw;
      end else begin
        crt = mem_q[rt];
      end
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
module tb_register_file_param;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs, rt, rw;
  logic [W-1:0]  dw;
  logic          rwe, clr;
  logic [W-1:0]  crs, crt, crs0, crt0;
  logic          busy, busy0;

  int total;
  int bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  register_file_param #(.WIDTH(W), .AW(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rw(rw), .dw(dw),
    .rwe(rwe), .clr(clr), .crs(crs), .crt(crt), .busy(busy)
  );

  register_file_param #(.WIDTH(W), .AW(AW), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rw(rw), .dw(dw),
    .rwe(rwe), .clr(clr), .crs(crs0), .crt(crt0), .busy(busy0)
  );

  // ---------------- tests ----------------
  task automatic test_reset();
    int cnt;
    rst_n = 1'b0; rs = 5'd5; rt = 5'd9; rw = '0; dw = '0; rwe = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    total++; if (crs !== '0) begin bad++; $display("FAIL reset_crs got=%h exp=0", crs); end
    total++; if (crt !== '0) begin bad++; $display("FAIL reset_crt got=%h exp=0", crt); end
    rst_n = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    total++; if (cnt != 32) begin bad++; $display("FAIL reset_sweep_len got=%0d exp=32", cnt); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs = AW'(i); rt = AW'(31 - i);
      #1;
      total++; if (crs !== '0) begin bad++; $display("FAIL reset_zero_crs[%0d] got=%h exp=0", i, crs); end
      total++; if (crt !== '0) begin bad++; $display("FAIL reset_zero_crt[%0d] got=%h exp=0", 31 - i, crt); end
      total++; if (crs0 !== '0) begin bad++; $display("FAIL reset_zero_crs_zr0[%0d] got=%h exp=0", i, crs0); end
    end
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    rw = 5'd7; dw = 32'h0000A52A; rwe = 1'b1; rs = 5'd7; rt = 5'd8;
    #1;
    total++; if (crs !== 32'h0000A52A) begin bad++; $display("FAIL bypass_crs got=%h exp=0000a52a", crs); end
    total++; if (crt !== 32'h0) begin bad++; $display("FAIL bypass_crt_other got=%h exp=0", crt); end
    @(posedge clk); #1;
    rwe = 1'b0; rt = 5'd7; rs = 5'd6;
    #1;
    total++; if (crt !== 32'h0000A52A) begin bad++; $display("FAIL write_crt got=%h exp=0000a52a", crt); end
    total++; if (crs !== 32'h0) begin bad++; $display("FAIL write_crs_other got=%h exp=0", crs); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    rw = 5'd0; dw = 32'hFFFFFFFF; rwe = 1'b1; rs = 5'd0; rt = 5'd0;
    #1;
    total++; if (crs !== 32'h0) begin bad++; $display("FAIL zero_during got=%h exp=0", crs); end
    total++; if (crs0 !== 32'hFFFFFFFF) begin bad++; $display("FAIL zr0_bypass got=%h exp=ffffffff", crs0); end
    @(posedge clk); #1;
    rwe = 1'b0;
    #1;
    total++; if (crs !== 32'h0) begin bad++; $display("FAIL zero_after got=%h exp=0", crs); end
    total++; if (crt !== 32'h0) begin bad++; $display("FAIL zero_after_crt got=%h exp=0", crt); end
    total++; if (crs0 !== 32'hFFFFFFFF) begin bad++; $display("FAIL zr0_after got=%h exp=ffffffff", crs0); end
  endtask

  task automatic test_clear();
    int cnt;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rw = AW'(i); dw = W'(i); rwe = 1'b1;
    end
    @(negedge clk);
    rwe = 1'b0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rs = AW'(i); rt = AW'(32 - i);
      #1;
      total++; if (crs !== W'(i)) begin bad++; $display("FAIL fill_crs[%0d] got=%h exp=%h", i, crs, W'(i)); end
      total++; if (crt !== W'(32 - i)) begin bad++; $display("FAIL fill_crt[%0d] got=%h exp=%h", 32 - i, crt, W'(32 - i)); end
    end
    // clr together with a write: write dropped, no bypass in this cycle
    @(negedge clk);
    clr = 1'b1; rwe = 1'b1; rw = 5'd3; dw = 32'h55; rs = 5'd3; rt = 5'd3;
    #1;
    total++; if (crs !== 32'd3) begin bad++; $display("FAIL clr_no_bypass got=%h exp=3", crs); end
    @(posedge clk); #1;
    clr = 1'b0;
    // writes during the sweep must be ignored as well
    rw = 5'd5; dw = 32'h1234; rs = 5'd5; rt = 5'd5;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      #1;
      total++; if (crs !== '0 || crt !== '0) begin
        bad++; $display("FAIL sweep_out_zero cyc=%0d got=%h/%h exp=0/0", cnt, crs, crt);
      end
      @(posedge clk); #1; cnt++;
    end
    rwe = 1'b0;
    total++; if (cnt != 32) begin bad++; $display("FAIL clr_sweep_len got=%0d exp=32", cnt); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs = AW'(i); rt = AW'(31 - i);
      #1;
      total++; if (crs !== '0 || crt !== '0) begin
        bad++; $display("FAIL clr_zero[%0d] got=%h/%h exp=0/0", i, crs, crt);
      end
    end
  endtask

  task automatic test_clr_in_sweep();
    int cnt;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (cnt == 10) clr = 1'b1;
      else clr = 1'b0;
      @(posedge clk); #1; cnt++;
    end
    clr = 1'b0;
    total++; if (cnt != 32) begin bad++; $display("FAIL clr_ignored_len got=%0d exp=32", cnt); end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    @(negedge clk);
    rw = 5'd9; dw = 32'h99; rwe = 1'b1;
    @(negedge clk);
    rwe = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_reset_busy got=%b exp=1", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    total++; if (cnt != 32) begin bad++; $display("FAIL mid_reset_len got=%0d exp=32", cnt); end
    @(negedge clk);
    rs = 5'd9; rt = 5'd7;
    #1;
    total++; if (crs !== '0) begin bad++; $display("FAIL mid_reset_reg9 got=%h exp=0", crs); end
    total++; if (crt !== '0) begin bad++; $display("FAIL mid_reset_reg7 got=%h exp=0", crt); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_clear();
    test_clr_in_sweep();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
